// File: rtl/io_out_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sapho_io_pkg
// Shared definitions for the processor output-port buffer (io_out_fifo) and
// its helper blocks.
//
// Contents:
//   NUBITS       default core data width
//   NUIOOU       default number of output port addresses
//   AW           address width derived from NUIOOU
//   OVF_CNT_W    width of the dropped-write counter
//   io_entry_t   one buffered output write {addr, data} at default widths
//   clog2_min1() pointer width helper that never returns zero
// ---------------------------------------------------------------------------
package sapho_io_pkg;

   localparam int NUBITS    = 32;
   localparam int NUIOOU    = 8;
   localparam int AW        = $clog2(NUIOOU);
   localparam int OVF_CNT_W = 8;

   // One captured core output write, address in the upper bits so that a
   // packed entry reads naturally as {addr, data}.
   typedef struct packed {
      logic [AW-1:0]     addr;
      logic [NUBITS-1:0] data;
   } io_entry_t;

   // A one-entry structure would give a zero-width pointer; clamp to 1 so
   // the helper is always safe to use for a port width.
   function automatic int clog2_min1(input int value);
      int w;
      w = $clog2(value);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/io_out_fifo_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ptr
// Wrapping FIFO pointer. The pointer is PW bits wide and the FIFO depth is a
// power of two, so natural binary overflow implements the modulo-DEPTH wrap.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, returns the pointer to 0
//   inc   in   advance the pointer by one this cycle
//   ptr   out  current pointer value (registered)
// ---------------------------------------------------------------------------
module fifo_ptr #(
   parameter int PW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   // Next-pointer value: step by one when enabled, wrap is implicit in the
   // PW-bit addition.
   always_comb begin
      ptr_d = ptr_q;
      if (inc) begin
         ptr_d = ptr_q + PW'(1);
      end
   end

   // Pointer register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/io_out_fifo.sv
// ---------------------------------------------------------------------------
// io_out_fifo
// Output-port buffer downstream of the processor core. Every core output
// write (out_en with addr_out/data_out) is captured as an {addr, data} entry
// in a first-word-fall-through FIFO and drained to the port logic over a
// valid/ready handshake.
//
// Build option:
//   IO_OUT_FIFO_OVF_EN  when defined, adds the ovf_cnt port: a saturating
//                       count of writes dropped because the FIFO was full.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (pointers, count, ovf_cnt)
//   out_en    in   core write strobe, one cycle per write
//   addr_out  in   core port address, valid with out_en
//   data_out  in   core data, valid with out_en
//   o_valid   out  head entry available
//   o_ready   in   consumer accepts the head entry
//   o_addr    out  head entry address (0 when empty)
//   o_data    out  head entry data (0 when empty)
//   full      out  all DEPTH entries occupied
//   empty     out  no entries occupied
//   count     out  number of occupied entries
//   ovf_cnt   out  dropped-write counter (IO_OUT_FIFO_OVF_EN only)
// ---------------------------------------------------------------------------
module io_out_fifo
   import sapho_io_pkg::*;
#(
   parameter int NUBITS = sapho_io_pkg::NUBITS,
   parameter int NUIOOU = sapho_io_pkg::NUIOOU,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(NUIOOU),
   localparam int PW    = clog2_min1(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 out_en,
   input  logic [AW-1:0]        addr_out,
   input  logic [NUBITS-1:0]    data_out,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [AW-1:0]        o_addr,
   output logic [NUBITS-1:0]    o_data,
   output logic                 full,
   output logic                 empty,
`ifdef IO_OUT_FIFO_OVF_EN
   output logic [PW:0]          count,
   output logic [OVF_CNT_W-1:0] ovf_cnt
`else
   output logic [PW:0]          count
`endif
);

   // Entry layout follows sapho_io_pkg::io_entry_t, but is declared here so
   // that overridden NUBITS/NUIOOU parameters still size it correctly.
   typedef struct packed {
      logic [AW-1:0]     addr;
      logic [NUBITS-1:0] data;
   } entry_t;

   localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count_q;
   logic [PW:0]   count_d;
   logic          push;
   logic          pop;
   entry_t        head;

   // Status flags come straight from the registered count, so nothing here
   // depends combinationally on out_en or o_ready.
   always_comb begin
      full    = (count_q == DEPTH_CNT);
      empty   = (count_q == '0);
      o_valid = ~empty;
      count   = count_q;
   end

   // Handshake decode. A pop frees a slot in the same cycle, which is why a
   // write into a full FIFO is still accepted when the head is leaving.
   always_comb begin
      pop  = o_valid & o_ready;
      push = out_en & (~full | pop);
   end

   fifo_ptr #(.PW(PW)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (push),
      .ptr (wr_ptr)
   );

   fifo_ptr #(.PW(PW)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (pop),
      .ptr (rd_ptr)
   );

   // Storage array. It is deliberately not reset: validity is tracked by the
   // pointers and count alone, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr] <= '{addr: addr_out, data: data_out};
      end
   end

   // Occupancy: push-only adds one, pop-only removes one, both or neither
   // leave it unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Head presentation. Outputs are forced to zero while empty so the port
   // side never sees stale or uninitialised storage.
   always_comb begin
      head   = mem_q[rd_ptr];
      o_addr = '0;
      o_data = '0;
      if (o_valid) begin
         o_addr = head.addr;
         o_data = head.data;
      end
   end

`ifdef IO_OUT_FIFO_OVF_EN
   logic [OVF_CNT_W-1:0] ovf_cnt_q;
   logic [OVF_CNT_W-1:0] ovf_cnt_d;

   // A write is dropped only when full and the head is not leaving; the
   // counter saturates so a long stall never wraps back to a small value.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (out_en && full && !pop && (ovf_cnt_q != '1)) begin
         ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: doc/io_out_fifo.md
# io_out_fifo

Output-port buffer sitting directly downstream of the processor core. It captures every output write the core issues, i.e. each out_en pulse with its addr_out and data_out. Each write is stored as an {address, data} entry in a small first-word-fall-through FIFO. Entries drain to the external port logic over a valid/ready handshake, so slow peripherals never stall or lose core output while the FIFO has room.

## Interface
- NUBITS, 32: data width; matches the core data path.
- NUIOOU, 8: number of output port addresses; must be ≥ 2; address width AW = $clog2(NUIOOU).
- DEPTH, 4: FIFO entries; power of two, ≥ 2; pointer width PW = $clog2(DEPTH).
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: reset, synchronous, active-high.
- out_en  in  1: write strobe from core, one cycle per write.
- addr_out  in  AW: port address from core, valid while out_en = 1.
- data_out  in  NUBITS: data from core, valid while out_en = 1.
- o_valid  out  1: head entry available.
- o_ready  in  1: consumer accepts head entry.
- o_addr  out  AW: head entry address.
- o_data  out  NUBITS: head entry data.
- full  out  1: count == DEPTH.
- empty  out  1: count == 0.
- count  out  PW+1: number of occupied entries.
- ovf_cnt  out  8: dropped-write counter; present only with IO_OUT_FIFO_OVF_EN.

## Operation
- push = out_en & (~full | pop); pop = o_valid & o_ready.
- On push, {addr_out, data_out} is written to wr_ptr and wr_ptr increments.
- On pop, rd_ptr increments.
- Pointers wrap modulo DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- o_valid = ~empty. o_addr/o_data = entry[rd_ptr] when o_valid, else forced to 0.
- Full with simultaneous pop: push accepted, count stays DEPTH.
- Full without pop: the write is dropped and the stored contents are untouched.
- Empty with out_en: no bypass; the entry is visible on the next cycle.
- pop while empty cannot occur (o_valid = 0), and o_ready is ignored.
- Consumer contract: o_valid, once high, stays high until pop. The head entry does not change until pop.
- Reset mid-operation clears pointers and count; all buffered entries are discarded. An out_en in the reset cycle is ignored.
- Storage array is not reset.

## Timing
- Reset values: o_valid 0, o_addr 0, o_data 0, full 0, empty 1, count 0, ovf_cnt 0.
- Write latency: out_en at edge k → o_valid = 1 after edge k (visible in cycle k+1).
- Throughput: one push and one pop per cycle sustained.
- full, empty and count are registered-state derived, with no combinational path from out_en.
- Outputs o_valid/o_addr/o_data have no combinational path from o_ready.
- Only pop logic depends on o_ready.

## Configuration
- IO_OUT_FIFO_OVF_EN defined:
  - ovf_cnt port exists.
  - Increments by 1 on each dropped write (out_en & full & ~pop).
  - Saturates at 255 and clears only on rst.
- Not defined: ovf_cnt port and its logic are absent; dropped writes are silently discarded. All other behaviour is identical.

## Structure
- Shared package sapho_io_pkg:
  - Typedef for the FIFO entry {addr, data}, parameterised through the AW/NUBITS localparams.
  - Constant OVF_CNT_W = 8.
- One sub-module is natural: fifo_ptr. It is a PW-bit wrapping pointer with an increment enable and synchronous reset, instantiated twice (wr, rd).
- Storage array and count logic are inline.

## Test plan
- Reset: assert rst 2 cycles with out_en = 1 → o_valid 0, empty 1, count 0, o_data 0, ovf_cnt 0.
- Single write: out_en = 1, addr_out = 3, data_out = 0xDEADBEEF at edge k, o_ready = 0 → from cycle k+1, o_valid 1, o_addr 3, o_data 0xDEADBEEF, count 1. o_ready = 1 for one cycle → empty 1.
- Fill and overflow (DEPTH 4): 5 writes, data 1..5, o_ready = 0 → full 1, count 4, data 5 dropped, ovf_cnt 1. Drain → order 1, 2, 3, 4.
- Full with simultaneous push/pop: full holding 1..4; out_en with data 9 and o_ready = 1 in the same cycle → count stays 4, ovf_cnt unchanged, drain order 2, 3, 4, 9.
- Streaming/wrap: 20 consecutive writes with o_ready = 1 every cycle → all 20 emitted in order, one per cycle, count ≤ 1, pointers wrap 5 times.
- Mid-operation reset: 3 entries stored, rst for 1 cycle → empty 1, count 0. Next write 0x55 is the first value out.
